mem_lock_scheduler: RTL and testbench
=====================================

// Module: mem_lock_scheduler
// PURPOSE
//  Round-robin lock scheduler for the shared dual-port data memory used by the cores.
//  Each core requests exclusive access; one requester at a time is granted the lock.
//  A bounded hold time prevents a core from starving the others, and an enforced
//  idle gap separates consecutive owners. Grant/revoke counts are kept for LED debug.
// PARAMETERS
//  N_REQ     2    number of requesters (cores), >=2
//  HOLD_MAX  64   max cycles one owner may hold the lock; 0 = unlimited
//  GAP       1    extra idle cycles inserted after every release/revoke
//  CNT_W     16   width of the saturating statistics counters
//  OWN_W     1    owner index width, = max(1, clog2(N_REQ))
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  req           in   N_REQ  lock request, one bit per core, level-sensitive
//  grant         out  N_REQ  one-hot lock grant, registered
//  locked        out  1      |grant
//  owner         out  OWN_W  index of current/last owner
//  revoked       out  N_REQ  one-cycle pulse: owner's lock forcibly removed
//  grant_count   out  CNT_W  saturating count of grants issued
//  revoke_count  out  CNT_W  saturating count of timeout revokes
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant=0, locked=0, owner=0, revoked=0,
//   both counters=0, hold cnt=0, gap cnt=0, rr pointer=0, block mask=0.
//  States: IDLE, OWNED, GAP.
//  IDLE: eligible = req & ~block. If eligible!=0, winner = first set bit searching
//   upward from rr pointer with wrap. Next edge: grant=onehot(winner), owner=winner,
//   grant_count++, rr pointer=(winner+1) mod N_REQ, hold cnt=0 -> OWNED.
//   Latency: req sampled high at edge k -> grant high after edge k+1 (1 cycle).
//  OWNED: hold cnt increments each cycle. Requests from non-owners are ignored.
//   req[owner]==0 -> grant=0 next edge, normal release -> GAP (IDLE if GAP==0).
//   HOLD_MAX!=0, req[owner]==1 and hold cnt==HOLD_MAX-1 -> revoke: grant=0,
//   revoked[owner]=1 for exactly one cycle, revoke_count++, block[owner]=1 -> GAP
//   (IDLE if GAP==0). Grant is therefore high for exactly HOLD_MAX cycles.
//   Owner drops req on the same cycle as expiry -> normal release, no revoke.
//  GAP: grant=0 for GAP cycles, then IDLE. Grant is low for GAP+1 cycles minimum
//   between owners (IDLE arbitration cycle included), also when GAP==0 (1 cycle).
//  Block mask: block[i] clears on any cycle req[i]==0; a revoked core must drop
//   and re-raise req before it is eligible again.
//  Counters saturate at all-ones, never wrap. owner holds last winner while unlocked.
//  Simultaneous requests: resolved solely by rr pointer; never more than one grant bit.
//  rst mid-grant: grant drops asynchronously with no clock edge; no revoked pulse.
// TESTING
//  1 rst=1, req=2'b11 -> grant=00, counters 0; drop rst, req=01 -> grant=01 one
//    cycle after first sampling edge; grant_count=1, locked=1, owner=0.
//  2 GAP=1, from reset req=11 -> grant=01; core0 drops req after 5 cycles ->
//    grant=00 for 2 cycles, then grant=10, owner=1, grant_count=2.
//  3 HOLD_MAX=8, req=01 held -> grant=01 for exactly 8 cycles, revoked=01 for 1
//    cycle, revoke_count=1; req0 stays high -> no regrant until req0 goes 0 then 1.
//  4 req=11 toggled by each owner after 3 cycles, 8 rounds -> grants alternate
//    01,10,01,...; grant_count=8, revoke_count=0, never two grant bits high.
//  5 owner 1 holding, assert rst between edges -> grant=00 at once; after release
//    with req=11 -> grant=01 (rr pointer back to 0).
//  6 CNT_W=2, 5 grant/release cycles -> grant_count stays 3 (saturated, no wrap).

Source files
------------

// File: rtl/mem_lock_scheduler.sv
// Round-robin lock scheduler for the shared dual-port data memory.
// One core at a time owns the lock. A bounded hold time stops a core from
// starving the others, and an idle gap separates consecutive owners.
// Saturating grant/revoke counters are kept for LED debug.
module mem_lock_scheduler #(
    parameter int N_REQ    = 2,
    parameter int HOLD_MAX = 64,
    parameter int GAP      = 1,
    parameter int CNT_W    = 16,
    parameter int OWN_W    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             locked,
    output logic [OWN_W-1:0] owner,
    output logic [N_REQ-1:0] revoked,
    output logic [CNT_W-1:0] grant_count,
    output logic [CNT_W-1:0] revoke_count
);

    localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWNED,
        S_GAP
    } state_t;

    state_t state, state_nxt;

    logic [OWN_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [N_REQ-1:0]  block, block_nxt;
    logic [N_REQ-1:0]  grant_nxt, revoked_nxt;
    logic [OWN_W-1:0]  owner_nxt;
    logic              grant_inc, revoke_inc;

    logic [N_REQ-1:0]  eligible;
    logic              found;
    logic [OWN_W-1:0]  winner;
    logic              expire;

    assign locked   = |grant;
    assign eligible = req & ~block;
    assign expire   = (HOLD_MAX != 0) && (hold_cnt == HOLD_W'(HOLD_MAX - 1));

    // Round-robin search: first eligible requester at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = OWN_W'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is cleared asynchronously; sequential blocks use <= only.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: grant from IDLE, release or revoke from OWNED, drain GAP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = S_OWNED;
                end
            end
            S_OWNED: begin
                if (!req[owner] || expire) begin
                    state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered grant, pulses and bookkeeping.
    always_comb begin
        grant_nxt    = grant;
        revoked_nxt  = '0;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        gap_cnt_nxt  = gap_cnt;
        block_nxt    = block & req;
        grant_inc    = 1'b0;
        revoke_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                grant_nxt = '0;
                if (found) begin
                    grant_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                    owner_nxt    = winner;
                    rr_ptr_nxt   = (winner == OWN_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    hold_cnt_nxt = '0;
                    grant_inc    = 1'b1;
                end
            end
            S_OWNED: begin
                hold_cnt_nxt = hold_cnt + 1'b1;
                if (!req[owner]) begin
                    grant_nxt   = '0;
                    gap_cnt_nxt = '0;
                end else if (expire) begin
                    grant_nxt          = '0;
                    gap_cnt_nxt        = '0;
                    revoked_nxt[owner] = 1'b1;
                    block_nxt[owner]   = 1'b1;
                    revoke_inc         = 1'b1;
                end
            end
            S_GAP: begin
                grant_nxt   = '0;
                gap_cnt_nxt = gap_cnt + 1'b1;
            end
            default: grant_nxt = '0;
        endcase
    end

    // Registered outputs, round-robin pointer, timers, block mask and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant        <= '0;
            revoked      <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            block        <= '0;
            grant_count  <= '0;
            revoke_count <= '0;
        end else begin
            grant    <= grant_nxt;
            revoked  <= revoked_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            block    <= block_nxt;
            if (grant_inc && (grant_count != '1)) begin
                grant_count <= grant_count + 1'b1;
            end
            if (revoke_inc && (revoke_count != '1)) begin
                revoke_count <= revoke_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_lock_scheduler.sv
// Self-checking bench for mem_lock_scheduler.
// dut: HOLD_MAX=8, GAP=1, CNT_W=16. dut_sat: unlimited hold, GAP=0, CNT_W=2.
// Both see the same clock, reset and request stream.
module tb_mem_lock_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req;

    logic [1:0]  grant, revoked;
    logic        locked;
    logic [0:0]  owner;
    logic [15:0] grant_count, revoke_count;

    logic [1:0]  grant_s, revoked_s;
    logic        locked_s;
    logic [0:0]  owner_s;
    logic [1:0]  grant_count_s, revoke_count_s;

    int n_cmp = 0;
    int n_bad = 0;

    mem_lock_scheduler #(
        .N_REQ(2), .HOLD_MAX(8), .GAP(1), .CNT_W(16), .OWN_W(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant), .locked(locked), .owner(owner), .revoked(revoked),
        .grant_count(grant_count), .revoke_count(revoke_count)
    );

    mem_lock_scheduler #(
        .N_REQ(2), .HOLD_MAX(0), .GAP(0), .CNT_W(2), .OWN_W(1)
    ) dut_sat (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant_s), .locked(locked_s), .owner(owner_s), .revoked(revoked_s),
        .grant_count(grant_count_s), .revoke_count(revoke_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst_first;
        logic [1:0] req;
        logic [1:0] grant;
        logic [1:0] revoked;
        logic       owner;
        logic [1:0] sat_grant;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit r, input logic [1:0] q, input logic [1:0] g,
                           input logic [1:0] rv, input logic o, input logic [1:0] sg);
        vec_t v;
        v.rst_first = r;
        v.req       = q;
        v.grant     = g;
        v.revoked   = rv;
        v.owner     = o;
        v.sat_grant = sg;
        vecs.push_back(v);
    endtask

    // Apply req, let one rising edge pass, return 1 time unit after it.
    task automatic cycle(input logic [1:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;

        // Two-owner handoff with GAP=1 (dut) and GAP=0 (dut_sat).
        add_vec(1, 2'b11, 2'b01, 2'b00, 1'b0, 2'b01);
        for (int i = 0; i < 4; i++) add_vec(0, 2'b11, 2'b01, 2'b00, 1'b0, 2'b01);
        add_vec(0, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00);
        add_vec(0, 2'b10, 2'b00, 2'b00, 1'b0, 2'b10);
        add_vec(0, 2'b10, 2'b10, 2'b00, 1'b1, 2'b10);
        // Timeout revoke at HOLD_MAX=8, then blocked until req drops and rises.
        add_vec(1, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01);
        for (int i = 0; i < 7; i++) add_vec(0, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01);
        add_vec(0, 2'b01, 2'b00, 2'b01, 1'b0, 2'b01);
        add_vec(0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01);
        add_vec(0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01);
        add_vec(0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01);
        add_vec(0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        add_vec(0, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01);

        // Test 1: reset state with requests pending, then first grant.
        rst = 1'b1;
        req = 2'b11;
        #2;
        check("t1 rst grant", 32'(grant), 32'h0);
        check("t1 rst locked", 32'(locked), 32'h0);
        check("t1 rst owner", 32'(owner), 32'h0);
        check("t1 rst revoked", 32'(revoked), 32'h0);
        check("t1 rst grant_count", 32'(grant_count), 32'h0);
        check("t1 rst revoke_count", 32'(revoke_count), 32'h0);
        @(posedge clk);
        #1;
        check("t1 held in reset", 32'(grant), 32'h0);
        rst = 1'b0;
        cycle(2'b01);
        check("t1 grant", 32'(grant), 32'h1);
        check("t1 locked", 32'(locked), 32'h1);
        check("t1 owner", 32'(owner), 32'h0);
        check("t1 grant_count", 32'(grant_count), 32'h1);

        // Tests 2 and 3: table-driven cycle vectors.
        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            cycle(vecs[i].req);
            check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("vec%0d locked", i), 32'(locked), 32'(|vecs[i].grant));
            check($sformatf("vec%0d revoked", i), 32'(revoked), 32'(vecs[i].revoked));
            check($sformatf("vec%0d owner", i), 32'(owner), 32'(vecs[i].owner));
            check($sformatf("vec%0d sat grant", i), 32'(grant_s), 32'(vecs[i].sat_grant));
            check($sformatf("vec%0d sat revoked", i), 32'(revoked_s), 32'h0);
        end
        check("t3 revoke_count", 32'(revoke_count), 32'h1);
        check("t3 grant_count", 32'(grant_count), 32'h2);
        check("t3 sat revoke_count", 32'(revoke_count_s), 32'h0);

        // Owner drops req on the expiry cycle: normal release, no revoke, no block.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(2'b01);
            check("t3b hold", 32'(grant), 32'h1);
        end
        cycle(2'b00);
        check("t3b release grant", 32'(grant), 32'h0);
        check("t3b release revoked", 32'(revoked), 32'h0);
        cycle(2'b01);
        check("t3b gap", 32'(grant), 32'h0);
        cycle(2'b01);
        check("t3b regrant", 32'(grant), 32'h1);
        check("t3b revoke_count", 32'(revoke_count), 32'h0);

        // Test 4: eight alternating rounds, each owner holds 3 cycles.
        do_reset();
        cycle(2'b11);
        for (int r = 0; r < 8; r++) begin
            exp_g = (r % 2 == 1) ? 2'b10 : 2'b01;
            check($sformatf("t4 r%0d grant", r), 32'(grant), 32'(exp_g));
            for (int k = 0; k < 2; k++) begin
                cycle(2'b11);
                check($sformatf("t4 r%0d hold", r), 32'(grant), 32'(exp_g));
                check($sformatf("t4 r%0d onehot", r), 32'($countones(grant) <= 1), 32'h1);
            end
            cycle(~exp_g);
            check($sformatf("t4 r%0d release", r), 32'(grant), 32'h0);
            cycle(2'b11);
            check($sformatf("t4 r%0d gap", r), 32'(grant), 32'h0);
            if (r < 7) cycle(2'b11);
        end
        check("t4 grant_count", 32'(grant_count), 32'd8);
        check("t4 revoke_count", 32'(revoke_count), 32'd0);

        // Test 5: asynchronous reset while core 1 owns the lock.
        do_reset();
        cycle(2'b10);
        check("t5 owner1 grant", 32'(grant), 32'h2);
        cycle(2'b10);
        check("t5 owner1 owner", 32'(owner), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t5 async grant", 32'(grant), 32'h0);
        check("t5 async locked", 32'(locked), 32'h0);
        check("t5 async revoked", 32'(revoked), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(2'b11);
        check("t5 rr restart", 32'(grant), 32'h1);
        check("t5 owner", 32'(owner), 32'h0);

        // Test 6: five grant/release rounds; CNT_W=2 counter saturates at 3.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            cycle(2'b01);
            check($sformatf("t6 r%0d grant", r), 32'(grant), 32'h1);
            check($sformatf("t6 r%0d sat grant", r), 32'(grant_s), 32'h1);
            check($sformatf("t6 r%0d sat count", r), 32'(grant_count_s),
                  32'((r + 1 > 3) ? 3 : r + 1));
            cycle(2'b00);
            cycle(2'b00);
            cycle(2'b00);
        end
        check("t6 grant_count", 32'(grant_count), 32'd5);
        check("t6 sat grant_count", 32'(grant_count_s), 32'd3);

        // Test 7: GAP=0 regrants after one low cycle; GAP=1 needs two.
        do_reset();
        cycle(2'b01);
        check("t7 sat locked", 32'(locked_s), 32'h1);
        cycle(2'b00);
        check("t7 sat released", 32'(grant_s), 32'h0);
        check("t7 released", 32'(grant), 32'h0);
        cycle(2'b01);
        check("t7 sat regrant", 32'(grant_s), 32'h1);
        check("t7 sat owner", 32'(owner_s), 32'h0);
        check("t7 still gap", 32'(grant), 32'h0);
        cycle(2'b01);
        check("t7 regrant", 32'(grant), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
